// File: rtl/otter_cu_fsm_if.sv
// Control-unit bus for the OTTER multicycle datapath: decoded IR fields and
// handshakes in, write enables / strobes / debug state out.
interface otter_cu_fsm_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             intr;
  logic             mie;
  logic             mem_ready;
  logic             pc_write;
  logic             reg_write;
  logic             csr_we;
  logic             mem_rden1;
  logic             mem_rden2;
  logic             mem_we2;
  logic             rf_reset;
  logic             int_taken;
  logic [2:0]       state;
  logic [CNT_W-1:0] instret;

  modport master (
    output opcode, funct3, intr, mie, mem_ready,
    input  pc_write, reg_write, csr_we, mem_rden1, mem_rden2, mem_we2,
           rf_reset, int_taken, state, instret
  );

  modport slave (
    input  opcode, funct3, intr, mie, mem_ready,
    output pc_write, reg_write, csr_we, mem_rden1, mem_rden2, mem_we2,
           rf_reset, int_taken, state, instret
  );
endinterface

// File: rtl/otter_cu_fsm.sv
// OTTER multicycle control FSM: INIT -> FETCH -> EXEC [-> WB] [-> INTR].
// Strobes are Mealy on state and inputs; state and INSTRET are registered.
module otter_cu_fsm #(
  parameter int INIT_CYCLES = 2,
  parameter int CNT_W       = 32
) (
  input logic            clk,
  input logic            rst_n,
  otter_cu_fsm_if.slave  cu
);
  localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [IW-1:0] INIT_LOAD = IW'(INIT_CYCLES - 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WB    = 3'd3,
    S_INTR  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    init_cnt;
  logic [CNT_W-1:0] instret_q;
  logic             retire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_INIT;
      init_cnt  <= INIT_LOAD;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      // Reload whenever outside INIT so an illegal-state recovery also waits.
      if (state_q != S_INIT)   init_cnt <= INIT_LOAD;
      else if (init_cnt != '0) init_cnt <= init_cnt - IW'(1);
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    cu.pc_write  = 1'b0;
    cu.reg_write = 1'b0;
    cu.csr_we    = 1'b0;
    cu.mem_rden1 = 1'b0;
    cu.mem_rden2 = 1'b0;
    cu.mem_we2   = 1'b0;
    cu.rf_reset  = 1'b0;
    cu.int_taken = 1'b0;
    case (state_q)
      S_INIT: begin
        cu.rf_reset = 1'b1;
        if (init_cnt == '0) state_d = S_FETCH;
      end
      S_FETCH: begin
        cu.mem_rden1 = 1'b1;
        if (cu.mem_ready) state_d = S_EXEC;
      end
      S_EXEC: begin
        case (cu.opcode)
          OP_LOAD: begin
            cu.mem_rden2 = 1'b1;
            if (cu.mem_ready) state_d = S_WB;
          end
          OP_STORE: begin
            cu.mem_we2  = 1'b1;
            cu.pc_write = cu.mem_ready;
          end
          OP_BRANCH: cu.pc_write = 1'b1;
          OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
            cu.pc_write  = 1'b1;
            cu.reg_write = 1'b1;
          end
          OP_SYS: begin
            cu.pc_write  = 1'b1;
            cu.reg_write = (cu.funct3 != 3'b000);
            cu.csr_we    = (cu.funct3 != 3'b000);
          end
          default: cu.pc_write = 1'b1;
        endcase
        retire = cu.pc_write;
      end
      S_WB: begin
        cu.reg_write = 1'b1;
        cu.pc_write  = 1'b1;
        retire       = 1'b1;
      end
      S_INTR: begin
        cu.int_taken = 1'b1;
        cu.pc_write  = 1'b1;
        state_d      = S_FETCH;
      end
      default: state_d = S_INIT;
    endcase
    // Interrupts are sampled only at instruction boundaries.
    if (retire) state_d = (cu.intr && cu.mie) ? S_INTR : S_FETCH;
  end

  assign cu.state   = state_q;
  assign cu.instret = instret_q;
endmodule
